eject_engine_rr: RTL and testbench
==================================

# eject_engine_rr

Parametrised, registered successor to the four-port combinational ejector in the router datapath. Each cycle it picks at most one locally-destined flit from `NUM_PORTS` router input ports using a round-robin pointer. The picked flit goes into a small ejection FIFO that drains to the local PE over a valid/ready handshake. It also kills the ejected flit in the pass-through path by clearing its valid bit, so the downstream deflection stage never sees it.

## Interface
- `FLIT_W`, 32, flit width in bits.
- `NUM_PORTS`, 4, number of router input ports (2..8).
- `DEST_LSB`, 4, LSB of the destination-port field.
- `DEST_W`, 3, width of the destination-port field.
- `LOCAL_CODE`, 3'b100, destination code meaning "local port".
- `VALID_BIT`, 1, bit index of the flit valid bit.
- `EJ_DEPTH`, 2, ejection FIFO depth (power of two, ≥2).
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `in_flits`  in  NUM_PORTS*FLIT_W  port i occupies bits [i*FLIT_W +: FLIT_W].
- `out_flits`  out  NUM_PORTS*FLIT_W  registered pass-through flits, same packing.
- `ej_data`  out  FLIT_W  FIFO head flit.
- `ej_valid`  out  1  FIFO non-empty.
- `ej_ready`  in  1  local PE accepts head.
- `ej_count`  out  clog2(EJ_DEPTH)+1  FIFO occupancy.
- `ej_stall`  out  1  registered; a local request existed last cycle but no grant was issued.
- `ej_total`  out  16  saturating count of flits ejected into the FIFO.

## Operation
- **Request.** `req[i]` = `in[i][VALID_BIT]` && `in[i][DEST_LSB +: DEST_W]` == `LOCAL_CODE`. Flits with the valid bit low never request.
- **Push enable.** `push_ok` = (`ej_count` < `EJ_DEPTH`). There is no same-cycle pop-to-push bypass, so at full occupancy nothing is granted even if a pop occurs.
- **Grant.**
  - Applies when `push_ok` and at least one `req` is set.
  - The winner is the first requesting index scanning `rr_ptr`, `rr_ptr+1`, … mod `NUM_PORTS`.
  - Exactly one grant per cycle.
- **Pointer update.** On a grant, `rr_ptr` ← (winner+1) mod `NUM_PORTS`. With no grant, it holds.
- **Kill.**
  - `out[i]` ← `in[i]` with `VALID_BIT` forced to 0 when i is the winner; otherwise `in[i]` unchanged.
  - Kill is by grant index, not by the source-port field, so identical flits on two ports cannot both be killed.
- **FIFO push.** The winner flit is pushed unmodified, with its valid bit still set.
- **FIFO pop.**
  - Pop occurs when `ej_valid` && `ej_ready`.
  - Push and pop may occur together when 0 < count < `EJ_DEPTH`; the count is then unchanged.
  - Pop at count 0 is impossible (`ej_valid`=0). `ej_ready` is a don't-care when `ej_valid`=0.
- **Order.** The FIFO is strictly first-in first-out. Read/write pointers wrap modulo `EJ_DEPTH`.
- **`ej_stall`.** Registered (any `req`) && !`push_ok`.
- **`ej_total`.** Increments on each grant and saturates at 16'hFFFF.
- **Reset values.**
  - `out_flits`=0.
  - FIFO empty: `ej_count`=0, `ej_valid`=0, `ej_data`=0 (storage cleared).
  - `rr_ptr`=0, `ej_stall`=0, `ej_total`=0.
  - Reset overrides any push or pop in the same cycle.

## Timing
- **Pass-through latency.** 1 cycle: `in_flits` sampled at edge t appears on `out_flits` after edge t.
- **Eject latency.**
  - A flit granted at edge t is written at edge t.
  - If the FIFO was empty, `ej_valid`=1 and `ej_data`=flit in the cycle after edge t.
- **Handshake.**
  - `ej_data` is stable while `ej_valid` && !`ej_ready`.
  - The head advances only on an edge where both are high.
- **Combinational paths.** None from `ej_ready` to `out_flits` or to the grant. The grant uses the registered `ej_count` only.
- **Throughput.** One ejection per cycle is sustainable when `ej_ready` is held high.
- **Reset mid-operation.** Asserting `rst` on any edge discards FIFO contents and in-flight pass-through flits. The first valid outputs follow one cycle after `rst` deasserts.

## Test plan
- **Single request.** Ports 0..3 with dest=3'b100 only on port 2 (valid=1, flit 32'h0000_0046), `ej_ready`=1 → next cycle `ej_data`=32'h0000_0046, `ej_valid`=1; `out` port 2 = 32'h0000_0044; other ports unchanged; `ej_total`=1.
- **Round robin.** All four ports request every cycle, `ej_ready`=1, from reset → grants 0,1,2,3,0 on consecutive cycles; exactly one killed port per cycle.
- **Full FIFO.** `ej_ready`=0 with port 1 requesting continuously → two grants, then `ej_count`=2. Following cycles: no kill, `out` port 1 valid=1, `ej_stall`=1. Raise `ej_ready` for one cycle → pop only, count 1; next cycle grant resumes.
- **Simultaneous push/pop.** Count=1, `ej_ready`=1, one request → count stays 1; order preserved (older flit popped first).
- **Non-local and invalid flits.** dest=3'b100 with valid=0, and dest=3'b010 with valid=1 → no grant, no kill, `ej_stall`=0, `out`==`in` delayed by one cycle.
- **Reset mid-stream.** FIFO holding 2 flits; assert `rst` for 1 cycle → `ej_valid`=0, `ej_count`=0, `out_flits`=0, `rr_ptr`=0, `ej_total`=0; the next all-port request grants port 0.

Source files
------------

// File: rtl/eject_engine_rr.sv
// eject_engine_rr: round-robin local ejection into a FIFO with kill of the ejected flit in the registered pass-through path
module eject_engine_rr #(
  parameter int FLIT_W = 32,
  parameter int NUM_PORTS = 4,
  parameter int DEST_LSB = 4,
  parameter int DEST_W = 3,
  parameter logic [DEST_W-1:0] LOCAL_CODE = 3'b100,
  parameter int VALID_BIT = 1,
  parameter int EJ_DEPTH = 2,
  localparam int CW = $clog2(EJ_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS*FLIT_W-1:0] in_flits,
  output logic [NUM_PORTS*FLIT_W-1:0] out_flits,
  output logic [FLIT_W-1:0]           ej_data,
  output logic                        ej_valid,
  input  logic                        ej_ready,
  output logic [CW-1:0]               ej_count,
  output logic                        ej_stall,
  output logic [15:0]                 ej_total
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(EJ_DEPTH);
  logic [NUM_PORTS-1:0] req;
  logic [FLIT_W-1:0] flit_arr [NUM_PORTS];
  logic [NUM_PORTS*FLIT_W-1:0] kill_flits;
  logic [FLIT_W-1:0] mem [EJ_DEPTH];
  logic [PW-1:0] rr_ptr, win, nxt_ptr;
  logic [PW:0] s;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic found, push_ok, grant, pop;
  assign push_ok = ej_count < CW'(EJ_DEPTH);
  assign grant = push_ok && |req;
  assign pop = ej_valid && ej_ready;
  assign ej_valid = ej_count != '0;
  assign ej_data = mem[rd_ptr];
  assign nxt_ptr = win == PW'(NUM_PORTS - 1) ? '0 : win + 1'b1;
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign flit_arr[i] = in_flits[i*FLIT_W +: FLIT_W];
    assign req[i] = flit_arr[i][VALID_BIT] && flit_arr[i][DEST_LSB +: DEST_W] == LOCAL_CODE;
    assign kill_flits[i*FLIT_W +: FLIT_W] = (grant && win == PW'(i)) ?
      flit_arr[i] & ~(FLIT_W'(1) << VALID_BIT) : flit_arr[i];
  end
  always_comb begin
    win = '0;
    found = 1'b0;
    s = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      s = {1'b0, rr_ptr} + (PW+1)'(k);
      s = s >= (PW+1)'(NUM_PORTS) ? s - (PW+1)'(NUM_PORTS) : s;
      if (!found && req[s[PW-1:0]]) begin
        win = s[PW-1:0];
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_flits <= '0;
      rr_ptr <= '0;
      ej_stall <= 1'b0;
      ej_total <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ej_count <= '0;
      for (int k = 0; k < EJ_DEPTH; k++) mem[k] <= '0;
    end else begin
      out_flits <= kill_flits;
      ej_stall <= |req && !push_ok;
      if (grant) begin
        mem[wr_ptr] <= flit_arr[win];
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= nxt_ptr;
        ej_total <= ej_total == 16'hFFFF ? ej_total : ej_total + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      ej_count <= ej_count + CW'(grant) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_eject_engine_rr.sv
// tb_eject_engine_rr: table-driven and scoreboard check of eject_engine_rr
module tb_eject_engine_rr;
  localparam int N = 4, W = 32;
  logic clk = 1'b0, rst = 1'b1, ej_ready = 1'b0;
  logic [N*W-1:0] in_flits = '0, out_flits;
  logic [W-1:0] ej_data;
  logic ej_valid, ej_stall;
  logic [1:0] ej_count;
  logic [15:0] ej_total;
  int checks = 0, errors = 0;
  logic [W-1:0] q[$];
  int m_ptr = 0, dut_win = -1;
  logic [15:0] m_total = '0;
  logic m_stall = 1'b0;
  logic [N*W-1:0] m_out = '0;
  typedef struct {logic [N*W-1:0] fl; logic rdy; int win; int cnt; logic stall;} vec_t;
  vec_t v[$];
  always #5 clk = ~clk;
  eject_engine_rr dut (.clk(clk), .rst(rst), .in_flits(in_flits), .out_flits(out_flits),
    .ej_data(ej_data), .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_count(ej_count),
    .ej_stall(ej_stall), .ej_total(ej_total));
  function automatic logic [W-1:0] lf(int t); return {24'(t), 8'h42}; endfunction
  function automatic logic [W-1:0] nl(int t); return {24'(t), 8'h22}; endfunction
  function automatic logic [W-1:0] iv(int t); return {24'(t), 8'h40}; endfunction
  function automatic logic [N*W-1:0] pk(logic [W-1:0] a, b, c, d); return {d, c, b, a}; endfunction
  function automatic logic [N*W-1:0] all_l(int t); return pk(lf(t), lf(t+1), lf(t+2), lf(t+3)); endfunction
  function automatic logic [N*W-1:0] none(); return pk(nl(1), nl(2), nl(3), nl(4)); endfunction
  function automatic logic [N*W-1:0] p1(int t); return pk(nl(1), lf(t), nl(2), nl(3)); endfunction
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", n, a, e);
    end
  endtask
  task automatic cycle(input logic [N*W-1:0] fl, input logic rdy);
    logic [N-1:0] req;
    logic pok;
    int w;
    in_flits = fl;
    ej_ready = rdy;
    for (int p = 0; p < N; p++) req[p] = fl[p*W+1] && fl[p*W+4 +: 3] == 3'b100;
    pok = q.size() < 2;
    w = -1;
    if (pok) for (int k = 0; k < N; k++) if (w < 0 && req[(m_ptr+k)%N]) w = (m_ptr + k) % N;
    if (rdy && q.size() > 0) chk("ej_pop_data", ej_data, q.pop_front());
    m_out = fl;
    if (w >= 0) begin
      q.push_back(fl[w*W +: W]);
      m_out[w*W+1] = 1'b0;
      m_ptr = (w + 1) % N;
      if (m_total != 16'hFFFF) m_total++;
    end
    m_stall = |req && !pok;
    @(posedge clk);
    #1;
    dut_win = -1;
    for (int p = 0; p < N; p++) if (fl[p*W+1] && !out_flits[p*W+1]) dut_win = dut_win == -1 ? p : -2;
    chk("kill_index", dut_win, w);
    chk("out_flits", out_flits, m_out);
    chk("ej_count", ej_count, q.size());
    chk("ej_valid", ej_valid, q.size() > 0);
    if (q.size() > 0) chk("ej_head", ej_data, q[0]);
    chk("ej_stall", ej_stall, m_stall);
    chk("ej_total", ej_total, m_total);
  endtask
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      cycle(v[i].fl, v[i].rdy);
      chk($sformatf("vec%0d_win", i), dut_win, v[i].win);
      chk($sformatf("vec%0d_count", i), ej_count, v[i].cnt);
      chk($sformatf("vec%0d_stall", i), ej_stall, v[i].stall);
    end
  endtask
  initial begin
    for (int c = 0; c < 5; c++) v.push_back('{all_l(16*c), 1'b1, c % 4, 1, 1'b0});
    v.push_back('{pk(iv(1), nl(2), iv(3), nl(4)), 1'b1, -1, 0, 1'b0});
    v.push_back('{none(), 1'b1, -1, 0, 1'b0});
    v.push_back('{p1(8'h11), 1'b0, 1, 1, 1'b0});
    v.push_back('{p1(8'h12), 1'b0, 1, 2, 1'b0});
    v.push_back('{p1(8'h13), 1'b0, -1, 2, 1'b1});
    v.push_back('{p1(8'h14), 1'b0, -1, 2, 1'b1});
    v.push_back('{p1(8'h15), 1'b1, -1, 1, 1'b1});
    v.push_back('{p1(8'h16), 1'b0, 1, 2, 1'b0});
    v.push_back('{none(), 1'b1, -1, 1, 1'b0});
    v.push_back('{pk(nl(5), nl(6), nl(7), lf(8'h21)), 1'b1, 3, 1, 1'b0});
    v.push_back('{none(), 1'b1, -1, 0, 1'b0});
    v.push_back('{pk(lf(8'h31), nl(6), nl(7), nl(8)), 1'b0, 0, 1, 1'b0});
    v.push_back('{pk(lf(8'h32), nl(6), nl(7), nl(8)), 1'b0, 0, 2, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out_flits, '0);
    chk("rst_valid", ej_valid, 1'b0);
    chk("rst_count", ej_count, 2'd0);
    chk("rst_data", ej_data, '0);
    chk("rst_stall", ej_stall, 1'b0);
    chk("rst_total", ej_total, 16'd0);
    rst = 1'b0;
    run_vecs(0, 6);
    cycle(pk(nl(5), nl(6), 32'h0000_0046, nl(7)), 1'b1);
    chk("single_data", ej_data, 32'h0000_0046);
    chk("single_valid", ej_valid, 1'b1);
    chk("single_kill", out_flits[2*W +: W], 32'h0000_0044);
    chk("single_pass0", out_flits[0 +: W], nl(5));
    chk("single_total", ej_total, 16'd6);
    run_vecs(6, v.size());
    rst = 1'b1;
    in_flits = all_l(8'h40);
    ej_ready = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    m_ptr = 0;
    m_total = '0;
    m_stall = 1'b0;
    chk("mid_rst_valid", ej_valid, 1'b0);
    chk("mid_rst_count", ej_count, 2'd0);
    chk("mid_rst_out", out_flits, '0);
    chk("mid_rst_total", ej_total, 16'd0);
    rst = 1'b0;
    cycle(all_l(8'h50), 1'b1);
    chk("post_rst_win", dut_win, 0);
    chk("post_rst_data", ej_data, lf(8'h50));
    cycle(none(), 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
